toe_rx_fifo: RTL and testbench
==============================

# toe_rx_fifo

Receive-side ingress buffer that sits directly upstream of the TCP offload engine (`toe`). It accepts framed 64-bit beats from the MAC receive path, stores each frame in store-and-forward fashion, and discards frames flagged bad, truncated, or too large for the buffer. Committed frames are presented to `toe` on its `i_valid`/`i_data` input, one entry popped per `i_read`.

## Interface
- `P_DATA_WIDTH`, 64: beat width; must match `toe`.
- `P_DEPTH_LOG2`, 9: log2 of buffer depth in beats (512).

- `clk` in 1: single clock for all logic.
- `rst_n` in 1: reset; asynchronous, active-low.
- `s_valid` in 1: MAC beat valid; no backpressure to the MAC.
- `s_data` in P_DATA_WIDTH: MAC beat data.
- `s_sop` in 1: first beat of frame.
- `s_eop` in 1: last beat of frame.
- `s_err` in 1: frame bad; sampled only on the `s_eop` beat.
- `o_valid` out 1: committed entry available; drives `toe.i_valid`.
- `o_data` out P_DATA_WIDTH: head entry data; drives `toe.i_data`.
- `o_eop` out 1: head entry is the last beat of its frame.
- `i_read` in 1: pop strobe from `toe`; pops when `i_read && o_valid`.
- `o_frame_cnt` out 16: frames committed (present only with `TOE_RX_STATS_EN`).
- `o_drop_cnt` out 16: frames dropped (present only with `TOE_RX_STATS_EN`).

## Operation
- Storage: 2^P_DEPTH_LOG2 entries of {eop, data}.
- Pointers are P_DEPTH_LOG2+1 bits with a wrap bit:
  - `rd_ptr`: head of the buffer.
  - `wr_ptr`: committed frame boundary.
  - `wr_tmp`: speculative write position.
- Speculative full: `wr_tmp - rd_ptr == 2^P_DEPTH_LOG2`, evaluated with pre-edge pointer values. A pop on the same edge does not free a slot for that edge.
- Write FSM (states IDLE, RECV, DROP); all events below are beats with `s_valid=1`:
  - IDLE, beat with `s_sop`: write at `wr_ptr`, `wr_tmp<=wr_ptr+1`, go to RECV. If `s_eop` is also set, apply the eop rule immediately and stay in IDLE.
  - IDLE, beat without `s_sop`: discard silently; not counted.
  - RECV, beat while speculative full: `wr_tmp<=wr_ptr`, go to DROP.
  - RECV, other beat: write at `wr_tmp`, `wr_tmp++`.
  - RECV, beat with `s_sop`: abort the open frame (rollback and count a drop), then start the new frame at `wr_ptr`.
  - Eop rule, good frame (`s_err=0`): `wr_ptr<=wr_tmp+1` (commit), count a frame, go to IDLE.
  - Eop rule, bad frame (`s_err=1`): `wr_tmp<=wr_ptr`, count a drop, go to IDLE.
  - DROP: discard beats. On `s_eop`, count a drop and go to IDLE. On `s_sop`, count a drop and start the new frame as in IDLE.
  - A frame longer than the buffer depth is always dropped.
- Read side:
  - `o_valid = (committed occupancy != 0)`; uncommitted beats are never visible.
  - Output is first-word-fall-through: `o_data`/`o_eop` are valid whenever `o_valid` is high.
  - `i_read` while `!o_valid` is ignored.

## Timing
- Reset values: `o_valid=0`, `o_data=0`, `o_eop=0`, all pointers 0, FSM=IDLE, counters 0.
- Reset is asynchronous. Asserting it mid-frame or mid-drain discards all contents.
- A write accepts 1 beat/cycle with no gaps required between frames.
- Read throughput is 1 pop/cycle sustained, concurrent with writes.
- Commit latency: good `s_eop` sampled at edge E, `wr_ptr` updates at E, `o_valid` is high after edge E+1.
- Pop: `i_read && o_valid` at edge E presents the next entry after edge E; `o_valid` drops after E if the buffer becomes empty.
- Simultaneous commit and pop of the last entry: `o_valid` stays high with no bubble beyond the commit latency.
- Pointer wrap: the wrap bit distinguishes full from empty.

## Configuration
- `TOE_RX_STATS_EN` defined:
  - `o_frame_cnt` and `o_drop_cnt` ports and counters exist.
  - Each counter increments by 1 per event and saturates at 0xFFFF.
- Not defined: ports and counter logic are absent; datapath behaviour is unchanged.

## Test plan
- Good 3-beat frame (sop on beat 1, eop on beat 3), `i_read=1` -> 3 entries out in consecutive cycles, `o_eop` on the 3rd entry only, `o_frame_cnt=1`.
- 4-beat frame with `s_err=1` on eop -> `o_valid` never asserts, `o_drop_cnt=1`, pointers unchanged.
- `P_DEPTH_LOG2=4`: 17-beat frame, then a 2-beat good frame -> first frame dropped (`o_drop_cnt=1`), exactly 2 entries delivered.
- `i_read=0` while three 4-beat good frames arrive back-to-back, then `i_read=1` -> 12 entries out in 12 consecutive cycles, `o_eop` on entries 4, 8, 12.
- `s_sop` on beat 3 of an open frame, then a 2-beat good frame -> only the 2 beats of the second frame delivered, `o_drop_cnt=1`, `o_frame_cnt=1`.
- Assert `rst_n=0` mid-frame with committed data pending -> `o_valid`/`o_data`/`o_eop` go to 0 without a clock edge; after release the buffer is empty.

Source files
------------

// File: rtl/toe_rx_fifo.sv
// Store-and-forward receive buffer in front of toe: only complete, good frames become visible.
// Defining TOE_RX_STATS_EN adds saturating o_frame_cnt / o_drop_cnt counters.
module toe_rx_fifo #(
   parameter int P_DATA_WIDTH = 64,
   parameter int P_DEPTH_LOG2 = 9
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    s_valid,
   input  logic [P_DATA_WIDTH-1:0] s_data,
   input  logic                    s_sop,
   input  logic                    s_eop,
   input  logic                    s_err,
   output logic                    o_valid,
   output logic [P_DATA_WIDTH-1:0] o_data,
   output logic                    o_eop,
   input  logic                    i_read
`ifdef TOE_RX_STATS_EN
   ,
   output logic [15:0]             o_frame_cnt,
   output logic [15:0]             o_drop_cnt
`endif
);

   localparam int              PW      = P_DEPTH_LOG2 + 1;
   localparam logic [PW-1:0]   DEPTH   = {1'b1, {P_DEPTH_LOG2{1'b0}}};
   localparam logic [PW-1:0]   PTR_ONE = PW'(1);
   localparam logic [1:0]      ST_IDLE = 2'd0;
   localparam logic [1:0]      ST_RECV = 2'd1;
   localparam logic [1:0]      ST_DROP = 2'd2;

   logic [P_DATA_WIDTH:0] mem [2**P_DEPTH_LOG2];
   logic [PW-1:0]         rd_ptr_q, wr_ptr_q, wr_tmp_q;
   logic [PW-1:0]         wr_ptr_d, wr_tmp_d, rd_next, tail;
   logic [1:0]            state_q, state_d;
   logic                  we, start, spec_full, commit_full, pop, head_ok;

   assign spec_full   = (wr_tmp_q - rd_ptr_q) == DEPTH;
   assign commit_full = (wr_ptr_q - rd_ptr_q) == DEPTH;

   // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
   always_comb begin
      state_d  = state_q;
      wr_ptr_d = wr_ptr_q;
      wr_tmp_d = wr_tmp_q;
      we       = 1'b0;
      start    = 1'b0;
      tail     = wr_tmp_q;
      if (s_valid) begin
         case (state_q)
            ST_IDLE: start = s_sop;
            ST_RECV: begin
               if (s_sop) begin
                  wr_tmp_d = wr_ptr_q;
                  start    = 1'b1;
               end else if (spec_full) begin
                  wr_tmp_d = wr_ptr_q;
                  state_d  = s_eop ? ST_IDLE : ST_DROP;
               end else begin
                  we = 1'b1;
               end
            end
            ST_DROP: begin
               if (s_sop)      start   = 1'b1;
               else if (s_eop) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase

         // A new frame always restarts from the committed boundary.
         if (start) begin
            tail = wr_ptr_q;
            if (commit_full) begin
               wr_tmp_d = wr_ptr_q;
               state_d  = s_eop ? ST_IDLE : ST_DROP;
            end else begin
               we = 1'b1;
            end
         end

         if (we) begin
            if (!s_eop) begin
               wr_tmp_d = tail + PTR_ONE;
               state_d  = ST_RECV;
            end else if (s_err) begin
               wr_tmp_d = wr_ptr_q;
               state_d  = ST_IDLE;
            end else begin
               wr_ptr_d = tail + PTR_ONE;
               wr_tmp_d = tail + PTR_ONE;
               state_d  = ST_IDLE;
            end
         end
      end
   end

   // NOTE: the storage array has no reset; pointers alone define what is valid.
   always_ff @(posedge clk) begin
      if (we) mem[tail[P_DEPTH_LOG2-1:0]] <= {s_eop, s_data};
   end

   assign pop     = i_read && o_valid;
   assign rd_next = rd_ptr_q + (pop ? PTR_ONE : '0);
   assign head_ok = wr_ptr_q != rd_next;

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         wr_ptr_q <= '0;
         wr_tmp_q <= '0;
         rd_ptr_q <= '0;
         o_valid  <= 1'b0;
         o_data   <= '0;
         o_eop    <= 1'b0;
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         wr_tmp_q <= wr_tmp_d;
         rd_ptr_q <= rd_next;
         o_valid  <= head_ok;
         if (head_ok) {o_eop, o_data} <= mem[rd_next[P_DEPTH_LOG2-1:0]];
      end
   end

`ifdef TOE_RX_STATS_EN
   // Every eop beat that belongs to a frame ends it: a moved wr_ptr means commit, otherwise drop.
   logic        frame_end, frame_evt, drop_end, abort;
   logic [16:0] frame_sum, drop_sum;

   assign frame_end = s_valid && s_eop && (s_sop || state_q != ST_IDLE);
   assign frame_evt = frame_end && (wr_ptr_d != wr_ptr_q);
   assign drop_end  = frame_end && (wr_ptr_d == wr_ptr_q);
   assign abort     = s_valid && s_sop && (state_q != ST_IDLE);
   assign frame_sum = {1'b0, o_frame_cnt} + {16'd0, frame_evt};
   assign drop_sum  = {1'b0, o_drop_cnt} + {16'd0, abort} + {16'd0, drop_end};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         o_frame_cnt <= '0;
         o_drop_cnt  <= '0;
      end else begin
         o_frame_cnt <= frame_sum[16] ? 16'hFFFF : frame_sum[15:0];
         o_drop_cnt  <= drop_sum[16]  ? 16'hFFFF : drop_sum[15:0];
      end
   end
`endif

endmodule

// File: tb/tb_toe_rx_fifo.sv
// Bench for toe_rx_fifo: vector table on a 512-deep instance, hand-written sequences on a 16-deep one.
module tb_toe_rx_fifo;

   localparam logic [63:0] BA = 64'hA000_0000_0000_0000;
   localparam logic [63:0] BB = 64'hB000_0000_0000_0000;
   localparam logic [63:0] BC = 64'hC000_0000_0000_0000;
   localparam logic [63:0] BD = 64'hD000_0000_0000_0000;
   localparam logic [63:0] BE = 64'hE000_0000_0000_0000;
   localparam logic [63:0] BF = 64'hF000_0000_0000_0000;
   localparam logic [63:0] BG = 64'h5A5A_0000_0000_0000;
   localparam logic [63:0] BH = 64'h3C3C_0000_0000_0000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        s_valid = 1'b0, s_sop = 1'b0, s_eop = 1'b0, s_err = 1'b0, rd = 1'b0;
   logic [63:0] s_data = '0;
   logic        v0, e0, v1, e1;
   logic [63:0] d0, d1;
`ifdef TOE_RX_STATS_EN
   logic [15:0] fc0, dc0, fc1, dc1;
`endif

   int n_vec = 0;
   int n_bad = 0;

   typedef struct {
      logic        v, sop, eop, err;
      logic [63:0] d;
      logic        rd;
      logic        ev;
      logic [63:0] ed;
      logic        ee;
      logic        cc;
      int          efc, edc;
   } vec_t;

   vec_t        vecs[$];
   logic [64:0] q1[$];

   always #5 clk = ~clk;

   toe_rx_fifo u0 (
      .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_data(s_data), .s_sop(s_sop),
      .s_eop(s_eop), .s_err(s_err), .o_valid(v0), .o_data(d0), .o_eop(e0), .i_read(rd)
`ifdef TOE_RX_STATS_EN
      , .o_frame_cnt(fc0), .o_drop_cnt(dc0)
`endif
   );

   toe_rx_fifo #(.P_DEPTH_LOG2(4)) u1 (
      .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_data(s_data), .s_sop(s_sop),
      .s_eop(s_eop), .s_err(s_err), .o_valid(v1), .o_data(d1), .o_eop(e1), .i_read(rd)
`ifdef TOE_RX_STATS_EN
      , .o_frame_cnt(fc1), .o_drop_cnt(dc1)
`endif
   );

   task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic add(input logic v, sop, eop, err, input logic [63:0] d, input logic r,
                      input logic ev, input logic [63:0] ed, input logic ee);
      vec_t t;
      t.v = v; t.sop = sop; t.eop = eop; t.err = err; t.d = d; t.rd = r;
      t.ev = ev; t.ed = ed; t.ee = ee; t.cc = 1'b0; t.efc = 0; t.edc = 0;
      vecs.push_back(t);
   endtask

   task automatic idle(input logic r, input logic ev, input logic [63:0] ed, input logic ee);
      add(1'b0, 1'b0, 1'b0, 1'b0, 64'd0, r, ev, ed, ee);
   endtask

   task automatic cnt_at_last(input int fc, input int dc);
      vecs[vecs.size()-1].cc  = 1'b1;
      vecs[vecs.size()-1].efc = fc;
      vecs[vecs.size()-1].edc = dc;
   endtask

   task automatic drive(input logic v, sop, eop, err, input logic [63:0] d, input logic r);
      s_valid = v; s_sop = sop; s_eop = eop; s_err = err; s_data = d; rd = r;
   endtask

   // Outputs are sampled at the falling edge, then the next inputs are driven for the rising edge.
   task automatic tick(input logic v, sop, eop, err, input logic [63:0] d, input logic r);
      @(negedge clk);
      if (r && v1) q1.push_back({e1, d1});
      drive(v, sop, eop, err, d, r);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      // Good 3-beat frame, streamed straight out.
      add(1, 1, 0, 0, BA + 0, 1, 0, 0, 0);
      add(1, 0, 0, 0, BA + 1, 1, 0, 0, 0);
      add(1, 0, 1, 0, BA + 2, 1, 0, 0, 0);
      idle(1, 0, 0, 0);
      idle(1, 1, BA + 0, 0);
      idle(1, 1, BA + 1, 0);
      idle(1, 1, BA + 2, 1);
      idle(1, 0, 0, 0);
      cnt_at_last(1, 0);
      // Bad 4-beat frame, then a stray beat outside any frame.
      for (int k = 0; k < 4; k++) add(1, k == 0, k == 3, k == 3, BB + 64'(k), 1, 0, 0, 0);
      add(1, 0, 1, 0, BB + 9, 1, 0, 0, 0);
      idle(1, 0, 0, 0);
      idle(1, 0, 0, 0);
      cnt_at_last(1, 1);
      // Three back-to-back 4-beat frames held, then drained.
      for (int k = 0; k < 12; k++)
         add(1, (k % 4) == 0, (k % 4) == 3, 0, BC + 64'(k), 0, k >= 5, BC, 0);
      for (int k = 0; k < 12; k++) idle(1, 1, BC + 64'(k), (k % 4) == 3);
      idle(1, 0, 0, 0);
      cnt_at_last(4, 1);
      // sop inside an open frame aborts it and starts a new one.
      add(1, 1, 0, 0, BD + 0, 1, 0, 0, 0);
      add(1, 0, 0, 0, BD + 1, 1, 0, 0, 0);
      add(1, 1, 0, 0, BE + 0, 1, 0, 0, 0);
      add(1, 0, 1, 0, BE + 1, 1, 0, 0, 0);
      idle(1, 0, 0, 0);
      idle(1, 1, BE + 0, 0);
      idle(1, 1, BE + 1, 1);
      idle(1, 0, 0, 0);
      cnt_at_last(5, 2);
      // Single-beat good frame, then single-beat bad frame.
      add(1, 1, 1, 0, BF, 1, 0, 0, 0);
      idle(1, 0, 0, 0);
      idle(1, 1, BF, 1);
      add(1, 1, 1, 1, BH, 1, 0, 0, 0);
      idle(1, 0, 0, 0);
      idle(1, 0, 0, 0);
      cnt_at_last(6, 3);

      #1;
      check("reset.valid", 65'(v0), 65'(0));
      check("reset.data", 65'(d0), 65'(0));
      check("reset.eop", 65'(e0), 65'(0));
`ifdef TOE_RX_STATS_EN
      check("reset.frame_cnt", 65'(fc0), 65'(0));
      check("reset.drop_cnt", 65'(dc0), 65'(0));
`endif
      @(negedge clk);
      #2 rst_n = 1'b1;

      foreach (vecs[i]) begin
         @(negedge clk);
         check($sformatf("vec%0d.valid", i), 65'(v0), 65'(vecs[i].ev));
         if (vecs[i].ev) begin
            check($sformatf("vec%0d.data", i), 65'(d0), 65'(vecs[i].ed));
            check($sformatf("vec%0d.eop", i), 65'(e0), 65'(vecs[i].ee));
         end
`ifdef TOE_RX_STATS_EN
         if (vecs[i].cc) begin
            check($sformatf("vec%0d.frame_cnt", i), 65'(fc0), 65'(vecs[i].efc));
            check($sformatf("vec%0d.drop_cnt", i), 65'(dc0), 65'(vecs[i].edc));
         end
`endif
         drive(vecs[i].v, vecs[i].sop, vecs[i].eop, vecs[i].err, vecs[i].d, vecs[i].rd);
      end

      // Clean reset before the 16-deep sequences.
      @(negedge clk);
      drive(0, 0, 0, 0, 0, 0);
      #2 rst_n = 1'b0;
      @(negedge clk);
      #2 rst_n = 1'b1;

      // 17-beat frame overflows the 16-deep buffer and is dropped; the next 2-beat frame survives.
      q1.delete();
      for (int k = 0; k < 17; k++) tick(1, k == 0, k == 16, 0, BD + 64'(k), 1);
      tick(1, 1, 0, 0, BE + 0, 1);
      tick(1, 0, 1, 0, BE + 1, 1);
      for (int k = 0; k < 8; k++) tick(0, 0, 0, 0, 0, 1);
      check("deep.entries", 65'(q1.size()), 65'(2));
      if (q1.size() >= 2) begin
         check("deep.entry0", q1[0], {1'b0, BE + 64'd0});
         check("deep.entry1", q1[1], {1'b1, BE + 64'd1});
      end
`ifdef TOE_RX_STATS_EN
      check("deep.frame_cnt", 65'(fc1), 65'(1));
      check("deep.drop_cnt", 65'(dc1), 65'(1));
`endif

      // Exactly 16 beats fill the buffer across the pointer wrap and are all delivered.
      q1.delete();
      for (int k = 0; k < 16; k++) tick(1, k == 0, k == 15, 0, BF + 64'(k), 0);
      for (int k = 0; k < 3; k++) tick(0, 0, 0, 0, 0, 0);
      check("fill.valid", 65'(v1), 65'(1));
      for (int k = 0; k < 20; k++) tick(0, 0, 0, 0, 0, 1);
      check("fill.entries", 65'(q1.size()), 65'(16));
      for (int k = 0; k < 16 && k < q1.size(); k++)
         check($sformatf("fill.entry%0d", k), q1[k], {k == 15, BF + 64'(k)});
      check("fill.empty", 65'(v1), 65'(0));
`ifdef TOE_RX_STATS_EN
      check("fill.frame_cnt", 65'(fc1), 65'(2));
      check("fill.drop_cnt", 65'(dc1), 65'(1));
`endif

      // Reset asserted between edges with a committed entry pending and a frame open.
      for (int k = 0; k < 10; k++) tick(0, 0, 0, 0, 0, 1);
      tick(1, 1, 1, 0, BG, 0);
      for (int k = 0; k < 3; k++) tick(0, 0, 0, 0, 0, 0);
      check("pend.valid", 65'(v0), 65'(1));
      check("pend.data", 65'(d0), 65'(BG));
      check("pend.eop", 65'(e0), 65'(1));
      tick(1, 1, 0, 0, BG + 1, 0);
      tick(1, 0, 0, 0, BG + 2, 0);
      #2 rst_n = 1'b0;
      drive(0, 0, 0, 0, 0, 0);
      #1;
      check("async_rst.valid", 65'(v0), 65'(0));
      check("async_rst.data", 65'(d0), 65'(0));
      check("async_rst.eop", 65'(e0), 65'(0));
`ifdef TOE_RX_STATS_EN
      check("async_rst.frame_cnt", 65'(fc0), 65'(0));
`endif
      @(negedge clk);
      #2 rst_n = 1'b1;
      for (int k = 0; k < 5; k++) tick(0, 0, 0, 0, 0, 1);
      check("post_rst.empty", 65'(v0), 65'(0));
      tick(1, 1, 1, 0, BH, 0);
      for (int k = 0; k < 3; k++) tick(0, 0, 0, 0, 0, 0);
      check("post_rst.valid", 65'(v0), 65'(1));
      check("post_rst.data", 65'(d0), 65'(BH));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
